// File: rtl/ppu_pkg.sv
// Shared ppu definitions: raster geometry, pixel byte layout and the frame sync marker.
package ppu_pkg;

  localparam int LINE   = 799;
  localparam int SCREEN = 524;
  localparam int HA_END = 639;
  localparam int VA_END = 479;

  // Byte layout on the vga_driver bus: R in [7:6], G in [5:4], B in [3:2], sync code in [1:0].
  typedef struct packed {
    logic [1:0] r;
    logic [1:0] g;
    logic [1:0] b;
    logic [1:0] sync;
  } ppu_pixel_t;

  localparam logic [7:0] SYNC_MARKER = 8'h03;

  typedef enum logic [1:0] {
    SLOT_PARK,
    SLOT_MARK,
    SLOT_ACTIVE,
    SLOT_BLANK
  } slot_e;

  // Strips the sync code so a stored byte can never alias the frame marker.
  function automatic logic [7:0] rgb_only(input ppu_pixel_t p);
    ppu_pixel_t q;
    q      = p;
    q.sync = 2'b00;
    return q;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy tracking; caller guarantees no push when full and no pop when empty.
module sync_fifo #(
  parameter int DEPTH     = 16,
  parameter int ADDR_BITS = 4,
  parameter int DATA_W    = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                push,
  input  logic                pop,
  input  logic [DATA_W-1:0]   wdata,
  output logic [DATA_W-1:0]   rdata,
  output logic [ADDR_BITS:0]  level,
  output logic                full,
  output logic                empty
);

  logic [DATA_W-1:0]    mem [DEPTH];
  logic [ADDR_BITS-1:0] wr_ptr_p1;
  logic [ADDR_BITS-1:0] rd_ptr_p1;
  logic [ADDR_BITS:0]   level_p1;

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_p1 <= '0;
      rd_ptr_p1 <= '0;
      level_p1  <= '0;
    end else begin
      if (push) wr_ptr_p1 <= wr_ptr_p1 + 1'b1;
      if (pop)  rd_ptr_p1 <= rd_ptr_p1 + 1'b1;
      if (push && !pop)      level_p1 <= level_p1 + 1'b1;
      else if (pop && !push) level_p1 <= level_p1 - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_p1] <= wdata;
  end

  assign rdata = mem[rd_ptr_p1];
  assign level = level_p1;
  assign full  = (level_p1 == (ADDR_BITS+1)'(DEPTH));
  assign empty = (level_p1 == '0);

endmodule

// File: rtl/ppu_pixel_fifo.sv
// Buffers ppu bytes and drains them one per pixel clock onto the vga_driver bus,
// paced by a local raster that emits a sync marker at every frame boundary.
module ppu_pixel_fifo
  import ppu_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int ADDR_BITS = 4,
  parameter int LINE      = ppu_pkg::LINE,
  parameter int SCREEN    = ppu_pkg::SCREEN,
  parameter int HA_END    = ppu_pkg::HA_END,
  parameter int VA_END    = ppu_pkg::VA_END
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [7:0]           data_i,
  input  logic                 stb_i,
  output logic                 ack_i,
  output logic [7:0]           pix_o,
  output logic                 frame_start_o,
  output logic [ADDR_BITS:0]   level_o,
  output logic                 full_o,
  output logic                 empty_o,
  output logic [15:0]          underflow_o
);

  localparam int DATA_W = 8;
  localparam int SX_W   = $clog2(LINE + 1);
  localparam int SY_W   = $clog2(SCREEN + 1);

  logic [SX_W-1:0]   sx_p0;
  logic [SY_W-1:0]   sy_p0;
  slot_e             slot_p0;
  logic              accept_p0;
  logic              pop_p0;
  logic [DATA_W-1:0] head_p0;

  logic              ack_p1;
  logic              vld_p1;
  logic [DATA_W-1:0] pix_p1;
  logic [15:0]       uf_p1;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Stage p0: handshake decision and slot decode from the current raster position.
  // Gating on ack_p1 stops the byte still held on stb during the ack cycle from entering twice.
  assign accept_p0 = stb_i & ~full_o & ~ack_p1;

  always_comb begin
    slot_p0 = SLOT_BLANK;
    if (!enable)
      slot_p0 = SLOT_PARK;
    else if (sx_p0 == SX_W'(LINE) && sy_p0 == SY_W'(SCREEN))
      slot_p0 = SLOT_MARK;
    else if (sx_p0 <= SX_W'(HA_END) && sy_p0 <= SY_W'(VA_END))
      slot_p0 = SLOT_ACTIVE;
  end

  assign pop_p0 = (slot_p0 == SLOT_ACTIVE) && !empty_o;

  sync_fifo #(
    .DEPTH     (DEPTH),
    .ADDR_BITS (ADDR_BITS),
    .DATA_W    (DATA_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (accept_p0),
    .pop   (pop_p0),
    .wdata (data_i),
    .rdata (head_p0),
    .level (level_o),
    .full  (full_o),
    .empty (empty_o)
  );

  // Parking at the marker slot means every (re)enable starts a fresh, aligned frame.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sx_p0 <= SX_W'(LINE);
      sy_p0 <= SY_W'(SCREEN);
    end else if (slot_p0 == SLOT_PARK) begin
      sx_p0 <= SX_W'(LINE);
      sy_p0 <= SY_W'(SCREEN);
    end else if (sx_p0 == SX_W'(LINE)) begin
      sx_p0 <= '0;
      sy_p0 <= (sy_p0 == SY_W'(SCREEN)) ? '0 : sy_p0 + 1'b1;
    end else begin
      sx_p0 <= sx_p0 + 1'b1;
    end
  end

  // Stage p1: registered bus outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ack_p1 <= 1'b0;
      vld_p1 <= 1'b0;
      pix_p1 <= '0;
      uf_p1  <= '0;
    end else begin
      ack_p1 <= accept_p0;
      vld_p1 <= (slot_p0 == SLOT_MARK);
      unique case (slot_p0)
        SLOT_MARK:   pix_p1 <= SYNC_MARKER;
        SLOT_ACTIVE: begin
          if (empty_o) begin
            pix_p1 <= '0;
            uf_p1  <= sat_inc(uf_p1);
          end else begin
            pix_p1 <= rgb_only(head_p0);
          end
        end
        default:     pix_p1 <= '0;
      endcase
    end
  end

  assign ack_i         = ack_p1;
  assign frame_start_o = vld_p1;
  assign pix_o         = pix_p1;
  assign underflow_o   = uf_p1;

endmodule
